// File: rtl/wb_stage_pkg.sv
// Shared constants and types for the write-back stage.
package wb_stage_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned RA_W_DEF  = 5;
  localparam int unsigned CNT_W_DEF = 32;

  // Write-back source select codes
  localparam logic [1:0] WD_ALU  = 2'd0;
  localparam logic [1:0] WD_DRAM = 2'd1;
  localparam logic [1:0] WD_PC4  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_LOAD = 2'd1,
    ST_COMMIT    = 2'd2
  } wb_state_e;

  // Load width codes (funct3)
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/wb_stage_load_ext.sv
// Load data align and sign/zero extend; byte offset comes from the address low bits.
module wb_load_ext
  import wb_stage_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] rd,
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  output logic [XLEN-1:0] data_c
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  // Pick the addressed lane and extend it according to the load width
  always_comb begin
    byte_c = rd[{offset, 3'b000} +: 8];
    half_c = rd[{offset[1], 4'b0000} +: 16];
    data_c = rd;
    case (funct3)
      F3_LB:   data_c = {{(XLEN-8){byte_c[7]}}, byte_c};
      F3_LH:   data_c = {{(XLEN-16){half_c[15]}}, half_c};
      F3_LBU:  data_c = {{(XLEN-8){1'b0}}, byte_c};
      F3_LHU:  data_c = {{(XLEN-16){1'b0}}, half_c};
      default: data_c = rd;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: captures the MEM/WB bundle, waits for load data,
// drives the register-file write port once per retired instruction and
// offers a same-cycle bypass to decode reads.
// Optional: define WB_LOAD_EXT_EN to align/extend load data by funct3.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned RA_W  = RA_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_valid,
  output logic             mem_ready,
  input  logic             mem_rf_we,
  input  logic [1:0]       mem_wd_sel,
  input  logic [RA_W-1:0]  mem_wR,
  input  logic [XLEN-1:0]  mem_alu_c,
  input  logic [XLEN-1:0]  mem_pc4,
  input  logic [2:0]       mem_funct3,
  input  logic             dram_rvalid,
  input  logic [XLEN-1:0]  dram_rd,
  output logic             rf_we,
  output logic [RA_W-1:0]  wR,
  output logic [XLEN-1:0]  wD,
  input  logic [RA_W-1:0]  byp_rR1,
  input  logic [RA_W-1:0]  byp_rR2,
  output logic             byp_hit1,
  output logic             byp_hit2,
  output logic [XLEN-1:0]  byp_d1,
  output logic [XLEN-1:0]  byp_d2,
  output logic [CNT_W-1:0] retired
);

  wb_state_e       state, state_next;

  logic            lat_we;
  logic [1:0]      lat_sel;
  logic [RA_W-1:0] lat_wr;
  logic [XLEN-1:0] lat_alu;
  logic [XLEN-1:0] lat_pc4;
  logic [2:0]      lat_f3;

  logic            capture_c;
  logic            enter_commit_c;
  logic            src_we_c;
  logic [1:0]      src_sel_c;
  logic [RA_W-1:0] src_wr_c;
  logic [XLEN-1:0] src_alu_c;
  logic [XLEN-1:0] src_pc4_c;
  logic [XLEN-1:0] load_val_c;
  logic [XLEN-1:0] wb_data_c;

  assign capture_c = mem_valid && mem_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state: captures go to WAIT_LOAD for loads, else straight to COMMIT
  always_comb begin
    state_next     = state;
    enter_commit_c = 1'b0;
    case (state)
      ST_IDLE, ST_COMMIT: begin
        if (capture_c)
          state_next = (mem_wd_sel == WD_DRAM) ? ST_WAIT_LOAD : ST_COMMIT;
        else
          state_next = ST_IDLE;
      end
      ST_WAIT_LOAD: begin
        if (dram_rvalid) state_next = ST_COMMIT;
      end
      default: state_next = ST_IDLE;
    endcase
    enter_commit_c = (state_next == ST_COMMIT);
  end

  // Latch the bundle on every handshake (needed later by a pending load)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_we  <= 1'b0;
      lat_sel <= WD_ALU;
      lat_wr  <= '0;
      lat_alu <= '0;
      lat_pc4 <= '0;
      lat_f3  <= '0;
    end else if (capture_c) begin
      lat_we  <= mem_rf_we;
      lat_sel <= mem_wd_sel;
      lat_wr  <= mem_wR;
      lat_alu <= mem_alu_c;
      lat_pc4 <= mem_pc4;
      lat_f3  <= mem_funct3;
    end
  end

`ifdef WB_LOAD_EXT_EN
  wb_load_ext #(.XLEN(XLEN)) u_load_ext (
    .rd     (dram_rd),
    .funct3 (lat_f3),
    .offset (lat_alu[1:0]),
    .data_c (load_val_c)
  );
`else
  logic unused_f3;
  assign load_val_c = dram_rd;
  assign unused_f3  = ^lat_f3;
`endif

  // Commit source: latched bundle when finishing a load, live bundle otherwise
  always_comb begin
    src_we_c  = mem_rf_we;
    src_sel_c = mem_wd_sel;
    src_wr_c  = mem_wR;
    src_alu_c = mem_alu_c;
    src_pc4_c = mem_pc4;
    if (state == ST_WAIT_LOAD) begin
      src_we_c  = lat_we;
      src_sel_c = lat_sel;
      src_wr_c  = lat_wr;
      src_alu_c = lat_alu;
      src_pc4_c = lat_pc4;
    end
    case (src_sel_c)
      WD_ALU:  wb_data_c = src_alu_c;
      WD_DRAM: wb_data_c = load_val_c;
      WD_PC4:  wb_data_c = src_pc4_c;
      default: wb_data_c = '0;
    endcase
  end

  // Registered outputs: write port is loaded on entry to COMMIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_ready <= 1'b1;
      rf_we     <= 1'b0;
      wR        <= '0;
      wD        <= '0;
      retired   <= '0;
    end else begin
      mem_ready <= (state_next != ST_WAIT_LOAD);
      rf_we     <= enter_commit_c && src_we_c && (src_wr_c != '0);
      if (enter_commit_c) begin
        wR <= src_wr_c;
        wD <= wb_data_c;
      end
      if (state == ST_COMMIT) retired <= retired + CNT_W'(1);
    end
  end

  // Same-cycle bypass of the write landing at the next edge
  assign byp_hit1 = rf_we && (byp_rR1 == wR);
  assign byp_hit2 = rf_we && (byp_rR2 == wR);
  assign byp_d1   = byp_hit1 ? wD : '0;
  assign byp_d2   = byp_hit2 ? wD : '0;

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back stage. It is the register-file writer that pairs with the decode-side register read path.
- Captures the MEM/WB bundle through a valid/ready handshake and waits for load data from data memory.
- Selects the write-back value and drives the register-file write port for exactly one cycle per retired instruction.
- Provides a same-cycle bypass to decode reads so that a write landing at the clock edge is not missed.

Parameters:
- XLEN, 32, datapath width.
- RA_W, 5, register address width.
- CNT_W, 32, retire counter width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- mem_valid  in  1  MEM stage offers a bundle.
- mem_ready  out  1  WB can accept a bundle.
- mem_rf_we  in  1  instruction writes a register.
- mem_wd_sel  in  2  write-back source: 0 = alu_c, 1 = dram_rd, 2 = npc_pc4, 3 = reserved (writes 0).
- mem_wR  in  RA_W  destination register.
- mem_alu_c  in  XLEN  ALU result.
- mem_pc4  in  XLEN  PC+4.
- mem_funct3  in  3  load width code; used only with WB_LOAD_EXT_EN.
- dram_rvalid  in  1  load data valid.
- dram_rd  in  XLEN  load data.
- rf_we  out  1  register-file write enable.
- wR  out  RA_W  register-file write address.
- wD  out  XLEN  register-file write data.
- byp_rR1, byp_rR2  in  RA_W  decode read addresses.
- byp_hit1, byp_hit2  out  1  bypass valid.
- byp_d1, byp_d2  out  XLEN  bypass data.
- retired  out  CNT_W  committed-instruction count.

Behaviour:
- States: IDLE, WAIT_LOAD, COMMIT.
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE and all WB registers clear.
  - rf_we=0, wR=0, wD=0, byp_hit*=0, byp_d*=0, retired=0, mem_ready=1 after reset.
  - A pending load is discarded and any dram_rvalid arriving during reset is ignored.
- mem_ready is 1 in IDLE and COMMIT, and 0 in WAIT_LOAD.
- Capture: a transfer happens when mem_valid && mem_ready. On a transfer, latch rf_we, wd_sel, wR, alu_c, pc4 and funct3.
- Next state after a capture:
  - mem_wd_sel==1 (load) goes to WAIT_LOAD.
  - Otherwise goes to COMMIT.
- WAIT_LOAD:
  - dram_rvalid is sampled only in this state.
  - When dram_rvalid=1, latch dram_rd and go to COMMIT.
  - Otherwise hold indefinitely; there is no timeout.
  - dram_rvalid in any other state is ignored. The MEM stage never returns data in the handoff cycle.
- COMMIT (lasts exactly one cycle):
  - rf_we = latched rf_we && (wR != 0). Writes to x0 are suppressed, but the instruction still retires.
  - wD is the selected source; wR is the latched address.
  - retired increments by 1, wrapping at 2^CNT_W.
  - Next state:
    - A capture in the same cycle goes to WAIT_LOAD or COMMIT per the new bundle.
    - No capture goes to IDLE.
  - Back-to-back non-load instructions therefore commit one per cycle.
- Latency:
  - Non-load: capture in cycle N, commit in cycle N+1.
  - Load: commit in the cycle after dram_rvalid.
- Outside COMMIT: rf_we=0. wR and wD hold their last values and have no meaning.
- Bypass (combinational):
  - byp_hitK = rf_we && (byp_rRK == wR). Since rf_we already excludes x0, a hit never occurs on x0.
  - byp_dK = wD when byp_hitK, else 0.
  - Both read ports may hit in the same cycle.

Optional Feature:
- Macro: WB_LOAD_EXT_EN.
- When defined, load data is extracted and extended according to mem_funct3, using alu_c[1:0] as the byte offset:
  - 000 = lb, sign-extend byte.
  - 001 = lh, sign-extend half; offset alu_c[1].
  - 010 = lw.
  - 100 = lbu, zero-extend byte.
  - 101 = lhu, zero-extend half.
  - Others: treated as lw.
- When not defined, dram_rd is written unmodified and mem_funct3 is unused.

Decomposition:
- Shared package holds:
  - Constants WD_ALU=2'd0, WD_DRAM=2'd1, WD_PC4=2'd2.
  - WB state encoding (IDLE, WAIT_LOAD, COMMIT).
  - Load funct3 codes.
- One natural sub-module: wb_load_ext, the combinational load align/extend, instantiated only under WB_LOAD_EXT_EN.

Test Plan:
- Reset mid-load: assert rst_n=0 while in WAIT_LOAD -> rf_we=0, retired=0 and mem_ready=1 after release. A later dram_rvalid produces no write.
- Back-to-back ALU ops: wR=5 with alu_c=0x11, then wR=6 with alu_c=0x22, in consecutive cycles -> rf_we high two consecutive cycles, writing x5=0x11 then x6=0x22; retired=2.
- Load with 3-cycle memory delay: wR=7, dram_rd=0xDEADBEEF -> mem_ready=0 for 3 cycles, then one write x7=0xDEADBEEF.
- jal link write: wd_sel=2, wR=1, pc4=0x40 -> x1=0x40. In the same cycle byp_rR1=1 and byp_rR2=1 give byp_hit1=byp_hit2=1 with both byp_d=0x40.
- x0 destination: wR=0, alu_c=0x55 -> rf_we=0, byp_hit*=0, retired still increments.
- With WB_LOAD_EXT_EN: lb with alu_c[1:0]=3 and dram_rd=0x80FFFFFF -> wD=0xFFFFFF80. lhu with alu_c[1]=1 and the same data -> wD=0x000080FF.
